// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader into instruction memory
// Holds the core in reset until a LEN/data/XOR-checksum frame is written and verified.
module imem_boot_loader #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        reload,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] words_loaded
);
   typedef enum logic [2:0] {
      S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state, state_n;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] shreg;
   logic [7:0]  csum;
   logic        wr_pend;
   logic [31:0] pend_addr;
   logic [31:0] pend_data;
   logic [15:0] len_full;
   logic        xfer;
   logic        word_end;
   logic        last_word;

   assign byte_ready = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
   assign xfer       = byte_valid && byte_ready;
   assign len_full   = {byte_in, len[7:0]};
   assign word_end   = (state == S_DATA) && xfer && (byte_cnt == 2'd3);
   assign last_word  = (word_idx == len - 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_LEN0;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_LEN0: if (xfer) state_n = S_LEN1;
         S_LEN1: begin
            if (xfer) begin
               if ({16'd0, len_full} > DEPTH_WORDS) state_n = S_ERR;
               else if (len_full == 16'd0)         state_n = S_CSUM;
               else                                 state_n = S_DATA;
            end
         end
         S_DATA: if (word_end && last_word) state_n = S_CSUM;
         S_CSUM: if (xfer) state_n = (byte_in == csum) ? S_DONE : S_ERR;
         S_DONE, S_ERR: if (reload) state_n = S_LEN0;
         default: state_n = S_LEN0;
      endcase
   end

   // The completed word is staged for one cycle so the write strobe lands at edge k+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len          <= 16'd0;
         word_idx     <= 16'd0;
         byte_cnt     <= 2'd0;
         shreg        <= 24'd0;
         csum         <= 8'd0;
         wr_pend      <= 1'b0;
         pend_addr    <= BASE_ADDR;
         pend_data    <= 32'd0;
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wdata   <= 32'd0;
         core_rst     <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= 16'd0;
      end else begin
         imem_we   <= wr_pend;
         wr_pend   <= 1'b0;
         core_rst  <= (state != S_DONE);
         load_done <= (state_n == S_DONE);
         load_err  <= (state_n == S_ERR);
         if (wr_pend) begin
            imem_addr    <= pend_addr;
            imem_wdata   <= pend_data;
            words_loaded <= words_loaded + 16'd1;
         end
         case (state)
            S_LEN0: if (xfer) len[7:0]  <= byte_in;
            S_LEN1: if (xfer) len[15:8] <= byte_in;
            S_DATA: begin
               if (xfer) begin
                  shreg    <= {byte_in, shreg[23:8]};
                  csum     <= csum ^ byte_in;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     wr_pend   <= 1'b1;
                     pend_data <= {byte_in, shreg};
                     pend_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                     word_idx  <= word_idx + 16'd1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (reload) begin
                  word_idx     <= 16'd0;
                  csum         <= 8'd0;
                  byte_cnt     <= 2'd0;
                  words_loaded <= 16'd0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench for imem_boot_loader
// Two instances share the stream; the second uses BASE_ADDR 0x100.
module tb_imem_boot_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_valid = 1'b0;
   logic        reload = 1'b0;

   logic        byte_ready0, imem_we0, core_rst0, load_done0, load_err0;
   logic [31:0] imem_addr0, imem_wdata0;
   logic [15:0] words_loaded0;
   logic        byte_ready1, imem_we1, core_rst1, load_done1, load_err1;
   logic [31:0] imem_addr1, imem_wdata1;
   logic [15:0] words_loaded1;

   int tests = 0;
   int fails = 0;
   int adj_cnt = 0;
   logic prev_we0 = 1'b0;
   logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
   logic [31:0] fw[$];

   imem_boot_loader u_dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready0), .reload(reload), .imem_we(imem_we0),
      .imem_addr(imem_addr0), .imem_wdata(imem_wdata0), .core_rst(core_rst0),
      .load_done(load_done0), .load_err(load_err0), .words_loaded(words_loaded0)
   );

   imem_boot_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0100)) u_dut_b (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready1), .reload(reload), .imem_we(imem_we1),
      .imem_addr(imem_addr1), .imem_wdata(imem_wdata1), .core_rst(core_rst1),
      .load_done(load_done1), .load_err(load_err1), .words_loaded(words_loaded1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we0) begin
         wa0.push_back(imem_addr0);
         wd0.push_back(imem_wdata0);
      end
      if (imem_we1) begin
         wa1.push_back(imem_addr1);
         wd1.push_back(imem_wdata1);
      end
      if (imem_we0 && prev_we0) adj_cnt++;
      prev_we0 = imem_we0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
      adj_cnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"}, 32'(byte_ready0), 32'd1);
      check({tag, "_core_rst"},   32'(core_rst0),   32'd1);
      check({tag, "_imem_we"},    32'(imem_we0),    32'd0);
      check({tag, "_imem_addr"},  imem_addr0,       32'h0);
      check({tag, "_imem_addr_b"}, imem_addr1,      32'h100);
      check({tag, "_imem_wdata"}, imem_wdata0,      32'h0);
      check({tag, "_load_done"},  32'(load_done0),  32'd0);
      check({tag, "_load_err"},   32'(load_err0),   32'd0);
      check({tag, "_words"},      32'(words_loaded0), 32'd0);
   endtask

   task automatic do_reset(input logic chk, input string tag);
      rst = 1'b1;
      byte_valid = 1'b0;
      reload = 1'b0;
      #2;
      if (chk) check_reset_outputs(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_log();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      byte_in = b;
      byte_valid = 1'b1;
      if (byte_ready0 !== 1'b1) check("ready_on_send", 32'(byte_ready0), 32'd1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap, input logic [7:0] csum_flip);
      logic [7:0]  cs;
      logic [7:0]  v;
      logic [15:0] n;
      cs = 8'd0;
      n = 16'(fw.size());
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
      foreach (fw[i]) begin
         for (int b = 0; b < 4; b++) begin
            v = fw[i][8*b +: 8];
            cs ^= v;
            send_byte(v, int'($urandom_range(0, max_gap)));
         end
      end
      send_byte(cs ^ csum_flip, 0);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwrites"}, 32'(wa0.size()), 32'(fw.size()));
      foreach (fw[i]) begin
         if (i < wa0.size() && i < wa1.size()) begin
            check({tag, "_addr"},   wa0[i], 32'(4 * i));
            check({tag, "_addr_b"}, wa1[i], 32'h100 + 32'(4 * i));
            check({tag, "_data"},   wd0[i], fw[i]);
            check({tag, "_data_b"}, wd1[i], fw[i]);
         end
      end
   endtask

   initial begin
      #1;
      do_reset(1'b1, "por");

      // single word: 01 00 13 05 50 00 46
      fw = '{32'h0050_0513};
      send_frame(0, 8'h00);
      check("w1_done_at_csum", 32'(load_done0), 32'd1);
      check("w1_core_rst_held", 32'(core_rst0), 32'd1);
      @(posedge clk); #1;
      check("w1_core_rst_rel", 32'(core_rst0), 32'd0);
      check("w1_words", 32'(words_loaded0), 32'd1);
      check("w1_ready", 32'(byte_ready0), 32'd0);
      check_writes("w1");

      // bad checksum 0x47
      do_reset(1'b0, "");
      send_frame(0, 8'h01);
      @(posedge clk); #1;
      check("bad_err", 32'(load_err0), 32'd1);
      check("bad_done", 32'(load_done0), 32'd0);
      check("bad_core_rst", 32'(core_rst0), 32'd1);
      check("bad_ready", 32'(byte_ready0), 32'd0);
      check_writes("bad");

      // oversize header 41 00
      do_reset(1'b0, "");
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      check("over_err", 32'(load_err0), 32'd1);
      check("over_ready", 32'(byte_ready0), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("over_nwrites", 32'(wa0.size()), 32'd0);

      // exactly DEPTH_WORDS is accepted
      do_reset(1'b0, "");
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      check("depth_ok_err", 32'(load_err0), 32'd0);
      check("depth_ok_ready", 32'(byte_ready0), 32'd1);

      // zero length, good and bad checksum
      do_reset(1'b0, "");
      fw = {};
      send_frame(0, 8'h00);
      @(posedge clk); #1;
      check("zero_done", 32'(load_done0), 32'd1);
      check("zero_core_rst", 32'(core_rst0), 32'd0);
      check("zero_nwrites", 32'(wa0.size()), 32'd0);
      do_reset(1'b0, "");
      send_frame(0, 8'h01);
      check("zero_bad_err", 32'(load_err0), 32'd1);

      // 3-word frame, back-to-back then with stalls
      fw = '{32'h0050_0513, 32'h00A0_0593, 32'h00B5_0633};
      for (int pass = 0; pass < 2; pass++) begin
         do_reset(1'b0, "");
         send_frame(pass * 2, 8'h00);
         @(posedge clk); #1;
         check("w3_done", 32'(load_done0), 32'd1);
         check("w3_done_b", 32'(load_done1), 32'd1);
         check("w3_err_b", 32'(load_err1), 32'd0);
         check("w3_core_rst_b", 32'(core_rst1), 32'd0);
         check("w3_ready_b", 32'(byte_ready1), 32'd0);
         check("w3_words", 32'(words_loaded0), 32'd3);
         check("w3_words_b", 32'(words_loaded1), 32'd3);
         check("w3_no_adjacent_we", 32'(adj_cnt), 32'd0);
         check_writes("w3");
      end

      // reset after the 2nd data byte
      do_reset(1'b0, "");
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      do_reset(1'b1, "midrst");
      fw = '{32'hDEAD_BEEF, 32'h1234_5678};
      send_frame(0, 8'h00);
      @(posedge clk); #1;
      check("w2_done", 32'(load_done0), 32'd1);
      check("w2_words", 32'(words_loaded0), 32'd2);
      check_writes("w2");

      // reload from DONE
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
      check("rl_ready", 32'(byte_ready0), 32'd1);
      check("rl_done", 32'(load_done0), 32'd0);
      check("rl_words", 32'(words_loaded0), 32'd0);
      @(posedge clk); #1;
      check("rl_core_rst", 32'(core_rst0), 32'd1);
      clear_log();
      fw = '{32'h0000_0073};
      send_frame(1, 8'h00);
      @(posedge clk); #1;
      check("rl2_done", 32'(load_done0), 32'd1);
      check("rl2_core_rst", 32'(core_rst0), 32'd0);
      check_writes("rl2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
